// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetches and load/store
// traffic onto a single byte-wide RAM/IO port with one-cycle read latency.
module mem_ctrl #(
  parameter int RD_LAT = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_done,
  output logic [31:0] ifu_data,
  input  logic        lsb_req,
  input  logic        lsb_we,
  input  logic [1:0]  lsb_width,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  localparam logic [3:0] LAT = 4'(RD_LAT);
  localparam logic [3:0] CAP = 4'(RD_LAT + 1);

  state_t      state;
  logic        last_ifu;
  logic [3:0]  step;
  logic [2:0]  len;
  logic [2:0]  idx;
  logic [31:0] base;
  logic [31:0] wbuf;

  logic        ifu_ok;
  logic        lsb_ok;
  logic        grant_ifu;
  logic        grant_lsb;
  logic        lsb_stall;
  logic        wr_stall;
  logic [2:0]  wr_nxt;
  logic [31:0] wr_addr;
  logic [7:0]  wr_byte;
  logic [3:0]  cap_sel;

  function automatic logic [2:0] len_of(input logic [1:0] width);
    case (width)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // A requester whose done is high this cycle is not eligible; ties go to the
  // side that was not granted last.
  always_comb begin
    ifu_ok    = ifu_req && !ifu_done;
    lsb_ok    = lsb_req && !lsb_done;
    grant_lsb = !clear && lsb_ok && (!ifu_ok || last_ifu);
    grant_ifu = !clear && ifu_ok && !grant_lsb;
    lsb_stall = (lsb_addr[17:16] == 2'b11) && io_buffer_full;
    wr_nxt    = mem_wr ? idx + 3'd1 : idx;
    wr_addr   = base + {29'd0, wr_nxt};
    wr_byte   = wbuf[{wr_nxt[1:0], 3'b000} +: 8];
    wr_stall  = (wr_addr[17:16] == 2'b11) && io_buffer_full;
    cap_sel   = step - CAP;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      last_ifu  <= 1'b1;
      step      <= 4'd0;
      len       <= 3'd0;
      idx       <= 3'd0;
      base      <= '0;
      wbuf      <= '0;
      ifu_done  <= 1'b0;
      lsb_done  <= 1'b0;
      ifu_data  <= '0;
      lsb_rdata <= '0;
      mem_wr    <= 1'b0;
      mem_a     <= '0;
      mem_dout  <= '0;
    end else if (rdy_in) begin
      ifu_done <= 1'b0;
      lsb_done <= 1'b0;
      case (state)
        IDLE: begin
          mem_a    <= '0;
          mem_wr   <= 1'b0;
          mem_dout <= '0;
          step     <= 4'd1;
          idx      <= 3'd0;
          if (grant_ifu) begin
            state    <= IF_RD;
            last_ifu <= 1'b1;
            base     <= ifu_addr;
            len      <= 3'd4;
            mem_a    <= ifu_addr;
            ifu_data <= '0;
          end else if (grant_lsb) begin
            last_ifu <= 1'b0;
            base     <= lsb_addr;
            wbuf     <= lsb_wdata;
            len      <= len_of(lsb_width);
            mem_a    <= lsb_addr;
            if (lsb_we) begin
              state    <= LS_WR;
              mem_wr   <= !lsb_stall;
              mem_dout <= lsb_wdata[7:0];
            end else begin
              state     <= LS_RD;
              lsb_rdata <= '0;
            end
          end
        end

        // step counts cycles since the grant; the address runs RD_LAT cycles
        // ahead of the byte being captured.
        IF_RD, LS_RD: begin
          if (clear) begin
            state <= IDLE;
            mem_a <= '0;
          end else begin
            mem_a <= (step < {1'b0, len}) ? base + {28'd0, step} : '0;
            if (step >= CAP) begin
              if (state == IF_RD) ifu_data[{cap_sel[1:0], 3'b000} +: 8] <= mem_din;
              else lsb_rdata[{cap_sel[1:0], 3'b000} +: 8] <= mem_din;
            end
            if (step == {1'b0, len} + LAT) begin
              state <= IDLE;
              mem_a <= '0;
              if (state == IF_RD) ifu_done <= 1'b1;
              else lsb_done <= 1'b1;
            end
            step <= step + 4'd1;
          end
        end

        // Stores ignore clear; a byte only advances once mem_wr was actually
        // high for it, so an IO stall simply re-presents the same byte.
        LS_WR: begin
          if (wr_nxt == len) begin
            state    <= IDLE;
            lsb_done <= 1'b1;
            mem_wr   <= 1'b0;
            mem_a    <= '0;
            mem_dout <= '0;
          end else begin
            idx      <= wr_nxt;
            mem_a    <= wr_addr;
            mem_dout <= wr_byte;
            mem_wr   <= !wr_stall;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a byte RAM beside the DUT, a transaction-level
// reference memory, directed corner cases and a randomized load/store/fetch mix.
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_done;
  logic [31:0] ifu_data;
  logic        lsb_req;
  logic        lsb_we;
  logic [1:0]  lsb_width;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int checks = 0;
  int failures = 0;
  int io_writes = 0;

  logic [7:0] ram [bit [31:0]];
  logic [7:0] ref_mem [bit [31:0]];

  mem_ctrl #(.RD_LAT(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_done(ifu_done), .ifu_data(ifu_data),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_width(lsb_width), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous RAM with one cycle of read latency, paused by rdy_in like the system's.
  always @(posedge clk_in) begin
    if (rdy_in) begin
      if (mem_wr) begin
        ram[mem_a] = mem_dout;
        if (mem_a[17:16] == 2'b11) io_writes++;
      end
      mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    end
  end

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic int len_of(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v |= 32'(ref_rd(a + 32'(i))) << (8 * i);
    return v;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] v);
    ram[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One transaction; clear_cyc / hold_cyc of 0 disable the flush and the rdy_in pause.
  task automatic applyStimulus(input bit is_ifu, input bit we, input logic [1:0] width,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int clear_cyc, input int hold_cyc, input int hold_len);
    int n, exp_done, done_cyc, eff;
    bit aborted;
    logic [31:0] exp_data;
    n = is_ifu ? 4 : len_of(width);
    exp_data = ref_word(addr, n);
    aborted = !we && (clear_cyc != 0);
    exp_done = (we ? n + 1 : n + 2) + ((hold_cyc != 0) ? hold_len : 0);
    @(negedge clk_in);
    if (is_ifu) begin
      ifu_req = 1'b1; ifu_addr = addr;
    end else begin
      lsb_req = 1'b1; lsb_we = we; lsb_width = width; lsb_addr = addr; lsb_wdata = wdata;
    end
    done_cyc = 0;
    for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
      @(negedge clk_in);
      eff = c;
      if (hold_cyc != 0 && c > hold_cyc) eff = (c <= hold_cyc + hold_len) ? hold_cyc : c - hold_len;
      if (!(aborted && c > clear_cyc) && eff <= n) begin
        checkOutput("mem_a", mem_a, addr + 32'(eff - 1));
        checkOutput("mem_wr", {31'd0, mem_wr}, {31'd0, we});
        if (we) checkOutput("mem_dout", {24'd0, mem_dout}, {24'd0, 8'(wdata >> (8 * (eff - 1)))});
      end
      if (aborted && c == clear_cyc + 1) checkOutput("abort_mem_a", mem_a, 32'd0);
      if (is_ifu ? ifu_done : lsb_done) begin
        done_cyc = c;
        checkOutput("other_done", {31'd0, is_ifu ? lsb_done : ifu_done}, 32'd0);
        checkOutput("done_mem_wr", {31'd0, mem_wr}, 32'd0);
        checkOutput("done_mem_a", mem_a, 32'd0);
      end
      if (c == hold_cyc) rdy_in = 1'b0;
      if (hold_cyc != 0 && c == hold_cyc + hold_len) rdy_in = 1'b1;
      if (c == clear_cyc) begin
        clear = 1'b1;
        if (aborted) begin
          if (is_ifu) ifu_req = 1'b0; else lsb_req = 1'b0;
        end
      end
      if (clear_cyc != 0 && c == clear_cyc + 1) clear = 1'b0;
    end
    if (aborted) begin
      checkOutput("no_done_after_clear", 32'(done_cyc), 32'd0);
    end else begin
      checkOutput("done_cycle", 32'(done_cyc), 32'(exp_done));
      if (!we) checkOutput(is_ifu ? "ifu_data" : "lsb_rdata", is_ifu ? ifu_data : lsb_rdata, exp_data);
      if (we) begin
        for (int i = 0; i < n; i++) begin
          ref_mem[addr + 32'(i)] = 8'(wdata >> (8 * i));
          checkOutput("ram_byte", {24'd0, env_rd(addr + 32'(i))}, {24'd0, ref_rd(addr + 32'(i))});
        end
      end
    end
    ifu_req = 1'b0;
    lsb_req = 1'b0;
    if (!aborted && done_cyc != 0) begin
      @(negedge clk_in);
      checkOutput("done_one_cycle", {31'd0, is_ifu ? ifu_done : lsb_done}, 32'd0);
    end
  endtask

  // Both sides request word reads at once; the winner finishes in cycle 6, the other in 12.
  task automatic arbitrate(input bit lsb_first, input logic [31:0] ia, input logic [31:0] la);
    int ic, lc;
    logic [31:0] exp_i, exp_l;
    exp_i = ref_word(ia, 4);
    exp_l = ref_word(la, 4);
    @(negedge clk_in);
    ifu_req = 1'b1; ifu_addr = ia;
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_width = 2'd2; lsb_addr = la;
    ic = 0; lc = 0;
    for (int c = 1; c <= 30 && (ic == 0 || lc == 0); c++) begin
      @(negedge clk_in);
      if (c == 1) checkOutput("arb_first_addr", mem_a, lsb_first ? la : ia);
      if (c == 7) checkOutput("arb_second_addr", mem_a, lsb_first ? ia : la);
      if (ifu_done && ic == 0) begin
        ic = c;
        checkOutput("arb_ifu_data", ifu_data, exp_i);
        ifu_req = 1'b0;
      end
      if (lsb_done && lc == 0) begin
        lc = c;
        checkOutput("arb_lsb_data", lsb_rdata, exp_l);
        lsb_req = 1'b0;
      end
    end
    ifu_req = 1'b0;
    lsb_req = 1'b0;
    checkOutput("arb_ifu_done_cycle", 32'(ic), lsb_first ? 32'd12 : 32'd6);
    checkOutput("arb_lsb_done_cycle", 32'(lc), lsb_first ? 32'd6 : 32'd12);
    @(negedge clk_in);
  endtask

  initial begin
    int wr_cyc, done_cyc, io_before, seen;
    logic [31:0] ra;
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
    ifu_req = 1'b0; ifu_addr = '0;
    lsb_req = 1'b0; lsb_we = 1'b0; lsb_width = 2'd0; lsb_addr = '0; lsb_wdata = '0;
    io_buffer_full = 1'b0;

    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    for (int i = 0; i < 4; i++) preload(32'h200 + 32'(i), 8'($urandom));
    for (int i = 0; i < 40; i++) preload(32'h80 + 32'(i), 8'($urandom));
    preload(32'hFFFF_FFFE, 8'hA1); preload(32'hFFFF_FFFF, 8'hB2);
    preload(32'h0, 8'hC3); preload(32'h1, 8'hD4);

    repeat (3) @(negedge clk_in);
    checkOutput("rst_ifu_done", {31'd0, ifu_done}, 32'd0);
    checkOutput("rst_lsb_done", {31'd0, lsb_done}, 32'd0);
    checkOutput("rst_ifu_data", ifu_data, 32'd0);
    checkOutput("rst_lsb_rdata", lsb_rdata, 32'd0);
    checkOutput("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    checkOutput("rst_mem_a", mem_a, 32'd0);
    checkOutput("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    rst_in = 1'b0;

    arbitrate(1'b1, 32'h100, 32'h200);
    arbitrate(1'b1, 32'h100, 32'h200);
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 0, 0, 0);
    checkOutput("fetch_0x100", ifu_data, 32'h0000_0513);
    applyStimulus(1'b0, 1'b1, 2'd1, 32'h1FFF, 32'hAABB_CCDD, 0, 0, 0);
    checkOutput("half_lo", {24'd0, env_rd(32'h1FFF)}, 32'hDD);
    checkOutput("half_hi", {24'd0, env_rd(32'h2000)}, 32'hCC);
    arbitrate(1'b0, 32'h100, 32'h200);

    // IO store held off by a full write buffer for three sampling edges.
    @(negedge clk_in);
    io_before = io_writes;
    io_buffer_full = 1'b1;
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_width = 2'd0; lsb_addr = 32'h0003_0000; lsb_wdata = 32'h0000_005A;
    wr_cyc = 0; done_cyc = 0;
    for (int c = 1; c <= 15 && done_cyc == 0; c++) begin
      @(negedge clk_in);
      if (c <= 3) checkOutput("io_stall_wr", {31'd0, mem_wr}, 32'd0);
      if (mem_wr && wr_cyc == 0) wr_cyc = c;
      if (lsb_done) done_cyc = c;
      if (c == 3) io_buffer_full = 1'b0;
    end
    lsb_req = 1'b0;
    io_buffer_full = 1'b0;
    ref_mem[32'h0003_0000] = 8'h5A;
    checkOutput("io_write_cycle", 32'(wr_cyc), 32'd4);
    checkOutput("io_done_cycle", 32'(done_cyc), 32'd5);
    checkOutput("io_write_count", 32'(io_writes - io_before), 32'd1);
    checkOutput("io_byte", {24'd0, env_rd(32'h0003_0000)}, 32'h5A);

    applyStimulus(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 3, 0, 0);
    applyStimulus(1'b0, 1'b1, 2'd2, 32'h90, $urandom, 2, 0, 0);

    // A request seen together with clear in IDLE must not start a transfer.
    @(negedge clk_in);
    clear = 1'b1;
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_width = 2'd0; lsb_addr = 32'h84;
    @(negedge clk_in);
    checkOutput("clear_blocks_grant", mem_a, 32'd0);
    clear = 1'b0; lsb_req = 1'b0;
    @(negedge clk_in);
    checkOutput("clear_blocks_done", {31'd0, lsb_done}, 32'd0);

    applyStimulus(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 0, 3, 2);
    applyStimulus(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0, 0, 0, 0);
    checkOutput("wrap_fetch", ifu_data, 32'hD4C3_B2A1);

    for (int k = 0; k < 40; k++) begin
      ra = 32'h80 + 32'($urandom_range(0, 31));
      io_buffer_full = 1'($urandom);
      case ($urandom_range(0, 2))
        0:       applyStimulus(1'b1, 1'b0, 2'd2, ra, 32'h0, 0, 0, 0);
        1:       applyStimulus(1'b0, 1'b0, 2'($urandom), ra, 32'h0, 0, 0, 0);
        default: applyStimulus(1'b0, 1'b1, 2'($urandom), ra, $urandom, 0, 0, 0);
      endcase
    end
    io_buffer_full = 1'b0;

    // Asynchronous reset pulse between edges in the middle of a word load.
    @(negedge clk_in);
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_width = 2'd2; lsb_addr = 32'h200;
    repeat (3) @(negedge clk_in);
    checkOutput("pre_reset_mem_a", mem_a, 32'h202);
    #1 rst_in = 1'b1;
    #1;
    checkOutput("async_rst_mem_a", mem_a, 32'd0);
    checkOutput("async_rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    checkOutput("async_rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    checkOutput("async_rst_lsb_rdata", lsb_rdata, 32'd0);
    checkOutput("async_rst_ifu_data", ifu_data, 32'd0);
    checkOutput("async_rst_lsb_done", {31'd0, lsb_done}, 32'd0);
    checkOutput("async_rst_ifu_done", {31'd0, ifu_done}, 32'd0);
    lsb_req = 1'b0;
    #1 rst_in = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_in);
      if (lsb_done) seen++;
    end
    checkOutput("no_done_after_reset", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, RAM read latency in cycles (address cycle to data-valid cycle); only value 1 supported.
REQ-002 SHALL have port clk_in  input  1  system clock; all registers on posedge.
REQ-003 SHALL have port rst_in  input  1  asynchronous active-high reset.
REQ-004 SHALL have port rdy_in  input  1  when low, every register holds its value.
REQ-005 SHALL have port clear  input  1  misprediction flush, qualified by rdy_in.
REQ-006 SHALL have ports ifu_req in 1, ifu_addr in 32, ifu_done out 1, ifu_data out 32: 4-byte instruction fetch.
REQ-007 SHALL have ports lsb_req in 1, lsb_we in 1, lsb_width in 2 (0 byte, 1 half, 2 word), lsb_addr in 32, lsb_wdata in 32, lsb_done out 1, lsb_rdata out 32.
REQ-008 SHALL have ports mem_din in 8, mem_dout out 8, mem_a out 32, mem_wr out 1 (1 = write): byte-wide RAM/IO port.
REQ-009 SHALL have port io_buffer_full  input  1  IO write buffer cannot accept a byte.

Function
REQ-010 SHALL implement FSM states IDLE, IF_RD, LS_RD, LS_WR.
REQ-011 In IDLE with one pending request, SHALL grant it at the sampling edge; with both pending, SHALL grant the requester not granted last (last-grant register resets to IFU, so LSB wins first).
REQ-012 Transfer length N SHALL be 4 for IF_RD and 1/2/4 for lsb_width 0/1/2; lsb_width 3 SHALL be treated as 2.
REQ-013 Counting the grant edge as edge 0, byte i (i = 0..N-1, little-endian) SHALL be addressed at mem_a = addr + i during cycle i+1; address arithmetic is 32-bit modulo 2^32.
REQ-014 Reads: byte i SHALL be captured from mem_din at edge i+2; done pulses high for exactly one cycle in cycle N+2 with data valid in that cycle; unused upper bytes SHALL be zero (no sign extension).
REQ-015 Writes: mem_wr=1 and mem_dout = lsb_wdata byte i during the cycle byte i is addressed; lsb_done SHALL pulse in cycle N+1.
REQ-016 The FSM SHALL return to IDLE at the edge that raises done; a new grant is possible at the next edge.
REQ-017 In the cycle a requester's done is high, its req SHALL be ignored by the arbiter; requesters hold req and address/data stable until done.
REQ-018 In IDLE: mem_wr=0, mem_a=0, mem_dout=0.
REQ-019 IO stall: during LS_WR, if mem_a[17:16]==2'b11 for the next byte and io_buffer_full=1, SHALL drive mem_wr=0, hold the byte index, and retry each cycle; done shifts later by the stall count.
REQ-020 clear (with rdy_in) SHALL abort IF_RD or LS_RD: FSM to IDLE at that edge, no done pulse, captured data discarded.
REQ-021 clear SHALL NOT abort LS_WR (stores are committed); the write completes and lsb_done pulses normally.
REQ-022 Requests sampled in IDLE in the same cycle as clear SHALL NOT be granted.
REQ-023 rdy_in low SHALL freeze FSM, counters, outputs; the system pauses RAM with the same rdy_in, so in-flight read data remains valid on resume.

Reset
REQ-024 rst_in high SHALL asynchronously force state IDLE, byte counters 0, last-grant IFU, ifu_done=0, lsb_done=0, ifu_data=0, lsb_rdata=0, mem_wr=0, mem_a=0, mem_dout=0, regardless of rdy_in.
REQ-025 Reset mid-transfer SHALL abandon the transfer with no done pulse; a partially written multi-byte store is not rolled back.

Verification
REQ-026 IFU fetch, ifu_addr=0x100, RAM bytes 13 05 00 00 -> mem_a 0x100..0x103 cycles 1..4, ifu_done in cycle 6 only, ifu_data=0x00000513.
REQ-027 ifu_req and lsb_req (word load 0x200) raised together after reset -> LSB served first, IFU granted at the edge after lsb_done; second simultaneous conflict goes to LSB again only if IFU was last granted.
REQ-028 Half store lsb_addr=0x1FFF, wdata=0xAABBCCDD -> mem_wr=1 cycles 1..2, bytes DD@0x1FFF, CC@0x2000, lsb_done in cycle 3, mem_wr=0 in cycle 3.
REQ-029 Byte store to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr=0 during stall, single write when full drops, lsb_done one cycle later.
REQ-030 clear asserted in cycle 3 of an IFU fetch -> no ifu_done, FSM IDLE in cycle 4; clear during a word store -> store completes, lsb_done in cycle 5.
REQ-031 rst_in pulsed asynchronously (between edges) mid-load -> all outputs 0 immediately, no lsb_done; rdy_in low 2 cycles mid-fetch -> done delayed exactly 2 cycles, data correct.
